// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesting agents and the round-robin arbiter.
// The arbiter side uses master; the requester/resource side uses slave.
interface rr_decode_arbiter_if;
  logic        enable;
  logic [15:0] req;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_onehot;

  modport master (
    input  enable,
    input  req,
    output grant_valid,
    output grant_idx,
    output grant_onehot
  );

  modport slave (
    output enable,
    output req,
    input  grant_valid,
    input  grant_idx,
    input  grant_onehot
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// 16-way round-robin arbiter with hold-time preemption, one dead cycle between
// owners, and a registered binary index plus its gated one-hot decode.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_decode_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic             r_valid;
  logic [3:0]       r_idx;
  logic [15:0]      r_onehot;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic             w_valid_nxt;
  logic [3:0]       w_idx_nxt;
  logic [15:0]      w_onehot_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_found;
  logic [3:0]       w_winner;
  logic [3:0]       w_cand;
  logic             w_others;
  logic             w_at_limit;
  logic             w_release;

  // Scan starts one past the pointer; k=16 wraps back to the pointer itself,
  // so the previous owner is considered last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_idx;
    w_cand   = r_idx;
    for (int unsigned k = 1; k <= 16; k++) begin
      w_cand = r_idx + 4'(k);
      if (!w_found && bus.req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_others   = |(bus.req & ~r_onehot);
    w_at_limit = (r_cnt == HOLD_LAST);
    w_release  = !bus.req[r_idx] || (w_at_limit && w_others);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_idx_nxt    = r_idx;
    w_onehot_nxt = r_onehot;
    w_cnt_nxt    = r_cnt;
    unique case (r_state)
      S_IDLE, S_RELEASE: begin
        if (bus.enable && w_found) begin
          w_state_nxt  = S_GRANT;
          w_valid_nxt  = 1'b1;
          w_idx_nxt    = w_winner;
          w_onehot_nxt = 16'(1) << w_winner;
          w_cnt_nxt    = '0;
        end else begin
          w_state_nxt  = S_IDLE;
          w_valid_nxt  = 1'b0;
          w_onehot_nxt = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt  = S_RELEASE;
          w_valid_nxt  = 1'b0;
          w_onehot_nxt = '0;
        end else if (!w_at_limit) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_valid_nxt  = 1'b0;
        w_onehot_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_idx    <= 4'hF;
      r_onehot <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_idx    <= w_idx_nxt;
      r_onehot <= w_onehot_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.grant_valid  = r_valid;
  assign bus.grant_idx    = r_idx;
  assign bus.grant_onehot = r_onehot;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=1) driven
// by the same inputs and compared each cycle against a rule-level model.
module tb_rr_decode_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_decode_arbiter_if ifa ();
  rr_decode_arbiter_if ifb ();

  rr_decode_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  rr_decode_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  logic        en  = 1'b0;
  logic [15:0] req = '0;
  assign ifa.enable = en;
  assign ifa.req    = req;
  assign ifb.enable = en;
  assign ifb.req    = req;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per instance, whether someone owns the resource, who (or who last
  // did), and how many cycles the current owner has already held it.
  int hold_lim [2] = '{8, 1};
  int m_valid  [2];
  int m_idx    [2];
  int m_held   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [15:0] r);
    for (int k = 1; k <= 16; k++) begin
      if (r[(last + k) % 16]) return (last + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_valid[d] = 0;
        m_idx[d]   = 15;
        m_held[d]  = 0;
      end else if (m_valid[d] != 0) begin
        logic [15:0] others;
        others = req & ~(16'(1) << m_idx[d]);
        if (!req[m_idx[d]] || (m_held[d] >= hold_lim[d] - 1 && others != 0))
          m_valid[d] = 0;
        else
          m_held[d]++;
      end else if (en && req != 0) begin
        m_idx[d]   = rr_pick(m_idx[d], req);
        m_valid[d] = 1;
        m_held[d]  = 0;
      end
    end
  endtask

  task automatic step();
    logic [15:0] exp_oh;
    @(posedge clk);
    model_edge();
    #1;
    exp_oh = (m_valid[0] != 0) ? (16'(1) << m_idx[0]) : 16'h0000;
    chk("a_valid",  32'(ifa.grant_valid),  32'(m_valid[0]));
    chk("a_idx",    32'(ifa.grant_idx),    32'(m_idx[0]));
    chk("a_onehot", 32'(ifa.grant_onehot), 32'(exp_oh));
    exp_oh = (m_valid[1] != 0) ? (16'(1) << m_idx[1]) : 16'h0000;
    chk("b_valid",  32'(ifb.grant_valid),  32'(m_valid[1]));
    chk("b_idx",    32'(ifb.grant_idx),    32'(m_idx[1]));
    chk("b_onehot", 32'(ifb.grant_onehot), 32'(exp_oh));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    int dead;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0;
      m_idx[d]   = 15;
      m_held[d]  = 0;
    end

    // Reset with every request asserted.
    rst = 1'b1; en = 1'b1; req = 16'hFFFF;
    steps(2);
    chk("rst_valid",  32'(ifa.grant_valid),  32'h0);
    chk("rst_idx",    32'(ifa.grant_idx),    32'hF);
    chk("rst_onehot", 32'(ifa.grant_onehot), 32'h0);
    rst = 1'b0;
    step();
    chk("first_idx",    32'(ifa.grant_idx),    32'h0);
    chk("first_onehot", 32'(ifa.grant_onehot), 32'h0001);
    req = 16'h0000;
    steps(4);

    // Single requester 5, then drop it.
    req = 16'h0020;
    steps(5);
    chk("single_idx", 32'(ifa.grant_idx), 32'h5);
    req = 16'h0000;
    steps(4);
    chk("single_idle_idx", 32'(ifa.grant_idx), 32'h5);

    // Two contenders: hold limit forces alternation 0 / 15.
    req = 16'h8001;
    steps(40);
    req = 16'h0000;
    steps(3);

    // Owner 14 preempted while 3 waits: the scan wraps 15,0,1,2,3.
    req = 16'h4000;
    steps(2);
    chk("wrap_owner", 32'(ifa.grant_idx), 32'hE);
    req = 16'h4008;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ifa.grant_valid && ifa.grant_idx != 4'hE) found = 1'b1;
    end
    chk("wrap_found", 32'(found), 32'h1);
    chk("wrap_idx",   32'(ifa.grant_idx), 32'h3);
    req = 16'h0000;
    steps(3);

    // Sole owner 7 keeps the grant indefinitely; 2 then preempts at once.
    req = 16'h0080;
    step();
    dead = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!ifa.grant_valid) dead++;
    end
    chk("sole_dead_cycles", 32'(dead), 32'h0);
    req = 16'h0084;
    step();
    chk("sole_preempt_gap", 32'(ifa.grant_valid), 32'h0);
    step();
    chk("sole_preempt_idx", 32'(ifa.grant_idx), 32'h2);
    req = 16'h0000;
    steps(3);

    // enable=0 blocks new grants; reset during a grant.
    en = 1'b0; req = 16'h0100;
    steps(5);
    chk("en_off_valid", 32'(ifa.grant_valid), 32'h0);
    en = 1'b1;
    step();
    chk("en_on_idx", 32'(ifa.grant_idx), 32'h8);
    en = 1'b0;
    steps(3);
    chk("en_off_keeps", 32'(ifa.grant_valid), 32'h1);
    rst = 1'b1;
    step();
    chk("midrst_idx", 32'(ifa.grant_idx), 32'hF);
    rst = 1'b0; en = 1'b1; req = 16'h0000;
    steps(2);

    // Random traffic with persistent requests and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) req = 16'($urandom) & 16'($urandom);
      en  = ($urandom_range(3) != 0);
      rst = ($urandom_range(63) == 0);
      step();
    end
    rst = 1'b0;
    steps(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
